spin_motor_sequencer: RTL and testbench
=======================================

# spin_motor_sequencer

Sequences the drum motor through a spin phase: accepts the spin speed chosen by the spin-speed selector, ramps the commanded RPM up to it in fixed steps, holds it, and ramps back down to zero. The block also handles load imbalance with bounded redistribution retries and aborts on door unlock. It sits between the spin-speed selector (which supplies the 11-bit target) and the motor drive (which consumes `motor_rpm`).

## Interface
- `RAMP_STEP`, 100: RPM added or removed per ramp tick.
- `TICK_DIV`, 10: clock cycles per ramp tick (≥2).
- `HOLD_TICKS`, 50: ticks spent at target speed.
- `MAX_RETRIES`, 3: imbalance retries allowed before fault.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level; begin spin phase when in IDLE.
- `selected_spin_speed` in 11: target RPM, latched at start.
- `door_locked` in 1: must be 1 to start; a 0 while active forces ramp-down.
- `imbalance` in 1: load-imbalance detector, sampled every cycle.
- `abort` in 1: user abort.
- `motor_rpm` out 11: commanded RPM.
- `phase` out 3: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4, FAULT=5.
- `busy` out 1: high in RAMP_UP, HOLD, RAMP_DOWN.
- `done` out 1: one-cycle pulse in DONE.
- `fault` out 1: high in FAULT.
- `retry_count` out 2: imbalance retries used in the current run.

## Operation
- Reset values: `motor_rpm`=0, `phase`=IDLE, `busy`=0, `done`=0, `fault`=0, `retry_count`=0. The divider counter and hold counter are 0, and the latched target is 0.
- IDLE: when `start`=1, `door_locked`=1 and `abort`=0:
  - Latch `selected_spin_speed` as the target.
  - Clear the divider, clear `retry_count`.
  - If target=0, go to DONE. Otherwise go to RAMP_UP.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` = (counter==TICK_DIV-1).
  - Runs continuously in all non-IDLE states and is cleared only on IDLE exit.
- RAMP_UP: on `tick`, rpm ← min(rpm+RAMP_STEP, target). Compute the sum at 12 bits so there is no 11-bit overflow. When the updated rpm equals target, go to HOLD on the same edge and clear the hold counter.
- HOLD: count ticks. On the HOLD_TICKS-th tick, go to RAMP_DOWN.
- RAMP_DOWN: on `tick`, rpm ← (rpm>RAMP_STEP) ? rpm-RAMP_STEP : 0. When the updated rpm is 0:
  - If the retry flag is set and `retry_count` < MAX_RETRIES: increment `retry_count`, clear the flag, go to RAMP_UP.
  - If the retry flag is set and `retry_count` = MAX_RETRIES: go to FAULT.
  - If the retry flag is clear: go to DONE.
- Imbalance: `imbalance`=1 in RAMP_UP or HOLD sets the retry flag and moves to RAMP_DOWN next edge. Imbalance is ignored in RAMP_DOWN.
- Abort: `abort`=1 or `door_locked`=0 in RAMP_UP, HOLD or RAMP_DOWN clears the retry flag and moves to (or stays in) RAMP_DOWN. The ramp-down therefore ends in DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- FAULT: `motor_rpm`=0 and `fault`=1. Stays in FAULT until `abort`=1, then goes to IDLE. `start` is ignored.
- Priority in one cycle, highest first: abort/door > imbalance > tick-driven transition.
- `start` while not in IDLE is ignored. Changes to `selected_spin_speed` after latching are ignored.

## Timing
- Let E be the edge that accepts `start`. `phase` becomes RAMP_UP after E and the divider is 0 in the cycle following E.
- The first rpm update lands at edge E+TICK_DIV; each subsequent update follows TICK_DIV cycles later.
- A target needs ceil(target/RAMP_STEP) ticks to reach; a final partial step clamps to the target.
- Imbalance or abort: registered state changes at the next edge. `motor_rpm` never jumps; it always ramps down in steps.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `reset` asserted mid-run forces all outputs to their reset values immediately (asynchronous).

## Test plan
- Bench parameters for all scenarios: TICK_DIV=2, RAMP_STEP=100, HOLD_TICKS=3, MAX_RETRIES=3.
- Nominal, target 400:
  - rpm steps 100/200/300/400 at E+2/4/6/8, and `phase`=HOLD from E+8.
  - RAMP_DOWN at E+14, rpm 0 at E+22.
  - `done` high one cycle after E+22, then IDLE.
- Target 450 → ramp 100..400 then 450. Target 0 → DONE then IDLE with rpm staying 0 and `busy` never high.
- Imbalance pulse in HOLD at target 800 → ramp down to 0, `retry_count`=1, ramp back to 800, then normal completion with `done`.
- Imbalance held high → four ramp-downs (retry_count reaches 3), then `phase`=FAULT with `fault`=1 and rpm 0. `abort` pulse → IDLE.
- Abort or door unlock mid-RAMP_UP at rpm 300 → rpm 200/100/0 → DONE. `start` while busy has no effect. Asserting `reset` mid-HOLD → all outputs 0 / IDLE immediately.

Source files
------------

// File: rtl/spin_motor_sequencer.sv
// Drum motor spin-phase sequencer: ramps commanded RPM up to a latched target,
// holds it, then ramps back to zero. Load imbalance triggers bounded
// redistribution retries. Abort or door unlock forces a clean ramp-down.
module spin_motor_sequencer #(
  parameter int unsigned RAMP_STEP   = 100,
  parameter int unsigned TICK_DIV    = 10,
  parameter int unsigned HOLD_TICKS  = 50,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] selected_spin_speed,
  input  logic        door_locked,
  input  logic        imbalance,
  input  logic        abort,
  output logic [10:0] motor_rpm,
  output logic [2:0]  phase,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  retry_count
);

  localparam int unsigned DivW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);
  localparam logic [11:0]      Step12   = 12'(RAMP_STEP);
  localparam logic [10:0]      Step11   = 11'(RAMP_STEP);
  localparam logic [1:0]       MaxRetry = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StHold     = 3'd2,
    StRampDown = 3'd3,
    StDone     = 3'd4,
    StFault    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [10:0]       rpm_q, rpm_d;
  logic [10:0]       target_q, target_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [1:0]        retry_q, retry_d;
  logic              flag_q, flag_d;

  logic        tick;
  logic        abort_req;
  logic        flag_eff;
  logic [11:0] sum12;
  logic [10:0] up_rpm;
  logic [10:0] down_rpm;

  // Next-state, ramp arithmetic and retry bookkeeping.
  always_comb begin
    state_d  = state_q;
    rpm_d    = rpm_q;
    target_d = target_q;
    div_d    = div_q;
    hold_d   = hold_q;
    retry_d  = retry_q;
    flag_d   = flag_q;

    tick      = (div_q == DivLast);
    abort_req = abort | ~door_locked;
    // Widen so rpm + step cannot wrap before the clamp to target.
    sum12     = {1'b0, rpm_q} + Step12;
    up_rpm    = (sum12 >= {1'b0, target_q}) ? target_q : sum12[10:0];
    down_rpm  = (rpm_q > Step11) ? (rpm_q - Step11) : 11'd0;
    flag_eff  = flag_q & ~abort_req;

    // Divider free-runs outside IDLE; it is cleared only when a run starts.
    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    case (state_q)
      StIdle: begin
        if (start && door_locked && !abort) begin
          target_d = selected_spin_speed;
          div_d    = '0;
          retry_d  = 2'd0;
          flag_d   = 1'b0;
          state_d  = (selected_spin_speed == 11'd0) ? StDone : StRampUp;
        end
      end
      StRampUp: begin
        if (abort_req) begin
          flag_d  = 1'b0;
          state_d = StRampDown;
        end else if (imbalance) begin
          flag_d  = 1'b1;
          state_d = StRampDown;
        end else if (tick) begin
          rpm_d = up_rpm;
          if (up_rpm == target_q) begin
            hold_d  = '0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (abort_req) begin
          flag_d  = 1'b0;
          state_d = StRampDown;
        end else if (imbalance) begin
          flag_d  = 1'b1;
          state_d = StRampDown;
        end else if (tick) begin
          if (hold_q == HoldLast) begin
            state_d = StRampDown;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
      StRampDown: begin
        // Abort only cancels a pending retry; the ramp itself keeps stepping.
        flag_d = flag_eff;
        if (tick) begin
          rpm_d = down_rpm;
          if (down_rpm == 11'd0) begin
            if (!flag_eff) begin
              state_d = StDone;
            end else if (retry_q < MaxRetry) begin
              retry_d = retry_q + 2'd1;
              flag_d  = 1'b0;
              state_d = StRampUp;
            end else begin
              state_d = StFault;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        rpm_d = 11'd0;
        if (abort) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rpm_q    <= 11'd0;
      target_q <= 11'd0;
      div_q    <= '0;
      hold_q   <= '0;
      retry_q  <= 2'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rpm_q    <= rpm_d;
      target_q <= target_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      retry_q  <= retry_d;
      flag_q   <= flag_d;
    end
  end

  assign motor_rpm   = rpm_q;
  assign phase       = state_q;
  assign busy        = (state_q == StRampUp) || (state_q == StHold) || (state_q == StRampDown);
  assign done        = (state_q == StDone);
  assign fault       = (state_q == StFault);
  assign retry_count = retry_q;

endmodule

// File: tb/tb_spin_motor_sequencer.sv
// Self-checking bench for spin_motor_sequencer: directed scenarios plus
// randomized disturbance runs, compared each cycle against a behavioural model.
module tb_spin_motor_sequencer;

  localparam int RAMP_STEP   = 100;
  localparam int TICK_DIV    = 2;
  localparam int HOLD_TICKS  = 3;
  localparam int MAX_RETRIES = 3;

  localparam int P_IDLE  = 0;
  localparam int P_UP    = 1;
  localparam int P_HOLD  = 2;
  localparam int P_DOWN  = 3;
  localparam int P_DONE  = 4;
  localparam int P_FAULT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] selected_spin_speed;
  logic        door_locked;
  logic        imbalance;
  logic        abort;
  logic [10:0] motor_rpm;
  logic [2:0]  phase;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  retry_count;

  int n_checks = 0;
  int n_errors = 0;
  string cur = "init";

  // Reference model: speed/phase of the run, ticks counted as edges since start.
  int m_phase, m_rpm, m_target, m_n, m_retry, m_flag, m_held;

  spin_motor_sequencer #(
    .RAMP_STEP  (RAMP_STEP),
    .TICK_DIV   (TICK_DIV),
    .HOLD_TICKS (HOLD_TICKS),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .selected_spin_speed(selected_spin_speed),
    .door_locked        (door_locked),
    .imbalance          (imbalance),
    .abort              (abort),
    .motor_rpm          (motor_rpm),
    .phase              (phase),
    .busy               (busy),
    .done               (done),
    .fault              (fault),
    .retry_count        (retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s/%s: observed %0d expected %0d", cur, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_rpm = 0; m_target = 0; m_n = 0;
    m_retry = 0; m_flag = 0; m_held = 0;
  endtask

  function automatic bit m_busy();
    return (m_phase == P_UP) || (m_phase == P_HOLD) || (m_phase == P_DOWN);
  endfunction

  // Apply one clock edge worth of specification rules to the model.
  task automatic model_edge();
    bit ab;
    bit tk;
    ab = abort || !door_locked;
    case (m_phase)
      P_IDLE: begin
        if (start && door_locked && !abort) begin
          m_target = int'(selected_spin_speed);
          m_n = 0; m_retry = 0; m_flag = 0;
          m_phase = (m_target == 0) ? P_DONE : P_UP;
        end
      end
      P_UP, P_HOLD: begin
        m_n++;
        tk = (m_n % TICK_DIV) == 0;
        if (ab) begin
          m_flag = 0; m_phase = P_DOWN;
        end else if (imbalance) begin
          m_flag = 1; m_phase = P_DOWN;
        end else if (tk) begin
          if (m_phase == P_UP) begin
            m_rpm = (m_rpm + RAMP_STEP < m_target) ? m_rpm + RAMP_STEP : m_target;
            if (m_rpm == m_target) begin
              m_phase = P_HOLD; m_held = 0;
            end
          end else begin
            m_held++;
            if (m_held == HOLD_TICKS) m_phase = P_DOWN;
          end
        end
      end
      P_DOWN: begin
        m_n++;
        tk = (m_n % TICK_DIV) == 0;
        if (ab) m_flag = 0;
        if (tk) begin
          m_rpm = (m_rpm > RAMP_STEP) ? m_rpm - RAMP_STEP : 0;
          if (m_rpm == 0) begin
            if (m_flag == 0) m_phase = P_DONE;
            else if (m_retry < MAX_RETRIES) begin
              m_retry++; m_flag = 0; m_phase = P_UP;
            end else m_phase = P_FAULT;
          end
        end
      end
      P_DONE:  m_phase = P_IDLE;
      P_FAULT: if (abort) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_all();
    check("rpm",   32'(motor_rpm),   m_rpm);
    check("phase", 32'(phase),       m_phase);
    check("busy",  32'(busy),        32'(m_busy()));
    check("done",  32'(done),        32'(m_phase == P_DONE));
    check("fault", 32'(fault),       32'(m_phase == P_FAULT));
    check("retry", 32'(retry_count), m_retry);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Modes: 0 none, 1 imbalance pulse in HOLD, 2 imbalance held, 3 abort at 300,
  // 4 door unlock at 300, 5 random disturbances.
  task automatic run(input string name, input int target, input int mode,
                     input int exp_done_k, input int exp_retry);
    int  k;
    int  done_k;
    int  fault_cyc;
    bit  pulsed;
    bit  saw_fault;
    cur = name;
    k = 0; done_k = -1; fault_cyc = 0; pulsed = 0; saw_fault = 0;
    selected_spin_speed = 11'(target);
    start = 1'b1; door_locked = 1'b1; abort = 1'b0;
    imbalance = (mode == 2);
    step();
    if (done === 1'b1) done_k = 0;
    start = 1'b0;
    for (int c = 0; c < 3000 && m_phase != P_IDLE; c++) begin
      selected_spin_speed = 11'($urandom);
      start       = m_busy() ? 1'($urandom_range(0, 1)) : 1'b0;
      abort       = 1'b0;
      door_locked = 1'b1;
      imbalance   = (mode == 2);
      case (mode)
        1: if (m_phase == P_HOLD && !pulsed) begin imbalance = 1'b1; pulsed = 1; end
        3: if (m_phase == P_UP && m_rpm == 300 && !pulsed) begin abort = 1'b1; pulsed = 1; end
        4: if (m_phase == P_UP && m_rpm == 300 && !pulsed) begin
             door_locked = 1'b0; pulsed = 1;
           end
        5: if (m_busy()) begin
             imbalance   = ($urandom_range(0, 99) < 3);
             abort       = ($urandom_range(0, 99) < 2);
             door_locked = !($urandom_range(0, 99) < 2);
           end
        default: ;
      endcase
      if (m_phase == P_FAULT) begin
        start = 1'b1;
        if (fault_cyc >= 3) abort = 1'b1;
        fault_cyc++;
      end
      step();
      k++;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (fault === 1'b1) saw_fault = 1;
    end
    check("end_idle", 32'(phase), P_IDLE);
    if (exp_done_k >= 0) check("done_cycle", done_k, exp_done_k);
    if (exp_retry >= 0) check("retry_final", 32'(retry_count), exp_retry);
    if (mode == 2) check("fault_seen", 32'(saw_fault), 1);
    start = 1'b0; abort = 1'b0; imbalance = 1'b0; door_locked = 1'b1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; selected_spin_speed = 11'd0;
    door_locked = 1'b1; imbalance = 1'b0; abort = 1'b0;
    model_reset();
    cur = "reset";
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // Directed scenarios with hand-derived completion edges.
    run("nominal400",  400, 0, 22, 0);
    run("target450",   450, 0, 26, 0);
    run("target0",       0, 0,  0, 0);
    run("imb_hold800", 800, 1, 70, 1);
    run("imb_held",    300, 2, -1, 3);
    run("abort300",    700, 3, 12, 0);
    run("door300",     700, 4, 12, 0);

    // Start with door open is ignored.
    cur = "door_open_start";
    door_locked = 1'b0; start = 1'b1; selected_spin_speed = 11'd500;
    step();
    step();
    start = 1'b0; door_locked = 1'b1;

    // Asynchronous reset in the middle of HOLD.
    cur = "reset_hold";
    selected_spin_speed = 11'd300; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100 && m_phase != P_HOLD; c++) step();
    check("reached_hold", 32'(phase), P_HOLD);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    step();

    // Randomized runs with random targets and disturbances.
    for (int i = 0; i < 16; i++) begin
      run($sformatf("rand%0d", i), int'($urandom_range(0, 2047)), (i % 4 == 0) ? 0 : 5,
          -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
